video_timing_gen: RTL and testbench
===================================

// Module: video_timing_gen
// PURPOSE
//  Source end of the vs/hs/de/data pixel stream consumed by the crop and processing blocks.
//  Generates frame timing: active, front porch, sync and back porch, horizontally and vertically.
//  Fills active pixels with a selectable test pattern (colour bars, ramp, frame-count level).
//  Used for bring-up and as a stimulus source in place of the sensor path.
// PARAMETERS
//  CNT_BITS   12    width of h/v counters; must hold H_TOTAL-1 and V_TOTAL-1
//  H_ACTIVE   1280  active pixels per line; multiple of 8
//  H_FP       110   horizontal front porch, clocks
//  H_SYNC     40    hs pulse width, clocks
//  H_BP       220   horizontal back porch, clocks
//  V_ACTIVE   720   active lines per frame
//  V_FP       5     vertical front porch, lines
//  V_SYNC     5     vs pulse width, lines
//  V_BP       20    vertical back porch, lines
// PORTS
//  clk_i          in   1   pixel clock
//  rst_i          in   1   synchronous, active-high reset
//  en_i           in   1   run request; level-sensitive
//  pattern_sel_i  in   2   0 = colour bars, 1 = h-ramp, 2 = frame level, 3 = black
//  vs_o           out  1   vertical sync, active-high
//  hs_o           out  1   horizontal sync, active-high
//  de_o           out  1   data enable, active-high
//  data_o         out  24  pixel {R[7:0],G[7:0],B[7:0]}; 0 when de_o=0
//  frame_start_o  out  1   1-cycle pulse coincident with the first de_o of each frame
//  busy_o         out  1   1 while state = RUN
// BEHAVIOUR
//  - Reset: all outputs 0; hc = vc = 0; frame_cnt = 0; state = IDLE; active pattern = 0.
//  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Line order per line: active, FP, sync, BP.
//  - FSM IDLE: counters held at 0; outputs 0.
//    - en_i=1 sampled -> RUN with hc=vc=0.
//  - FSM RUN: hc increments every clock and wraps at H_TOTAL-1; vc increments on hc wrap and wraps at V_TOTAL-1.
//    - At the last clock of a frame (hc=H_TOTAL-1, vc=V_TOTAL-1): en_i=0 -> IDLE; else start a new frame.
//    - en_i deassert mid-frame never truncates the frame.
//  - Decode:
//    - de = hc<H_ACTIVE && vc<V_ACTIVE
//    - hs = H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC, on every line including vertical blanking
//    - vs = V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC, for whole lines; edges align with hc=0
//  - Latency: all outputs registered, 1 clk after counter state.
//    - en_i sampled at edge N -> first de_o=1 after edge N+1.
//    - Frame period is exactly H_TOTAL*V_TOTAL clocks.
//  - pattern_sel_i is captured only at hc=0,vc=0; changes mid-frame have no effect until the next frame.
//  - Patterns (bar width = H_ACTIVE/8):
//    - 0 colour bars: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000
//    - 1 h-ramp: {3{hc[7:0]}}
//    - 2 frame level: {3{frame_cnt[7:0]}}
//    - 3 black: 000000
//  - frame_cnt: 8 bits; increments at each frame end in RUN; wraps 255->0; not cleared on IDLE.
//  - Reset mid-operation: next cycle, all outputs 0 and state IDLE. No partial-line completion.
// CONFIGURATION
//  VTG_BORDER_EN defined:
//    - pixels with hc=0, hc=H_ACTIVE-1, vc=0 or vc=V_ACTIVE-1 output FFFFFF, overriding the pattern.
//    - Used to check edge cropping downstream.
//  VTG_BORDER_EN undefined:
//    - pattern covers every active pixel; no extra logic.
// STRUCTURE
//  vtg_pkg:
//    - bar colour constants; pattern select enum
//    - FSM state enum {IDLE, RUN}
//    - BORDER_COLOR = 24'hFFFFFF
//  Sub-module vtg_pattern:
//    - combinational pixel-value generator (hc, vc, frame_cnt, pattern, border) -> 24-bit pixel
//    - top holds counters, FSM, sync decode and output registers.
// TESTING
//  Small config for all tests: H 16/2/3/3 (H_TOTAL=24), V 4/1/2/1 (V_TOTAL=8).
//  - en_i=1 held from reset release, sel=0
//    -> frame_start_o period 192 clks
//    -> 16 de_o clocks per line, 4 de_o lines per frame
//    -> hs_o high 3 clks starting 2 clks after de_o falls
//    -> vs_o high for 48 clks starting at the line after the 1st blanking line
//  - Colour bars, sel=0
//    -> data_o pixels 0-1 = FFFFFF, 2-3 = FFFF00, ..., 14-15 = 000000
//    -> data_o = 0 whenever de_o=0
//  - en_i dropped at clk 50 of frame
//    -> frame completes to clk 191
//    -> busy_o falls; no further de_o
//    -> re-raise en_i: first de_o 2 clks later
//  - sel changed 0->1 mid-frame
//    -> current frame stays bars
//    -> next frame pixel n = {3{n}}
//  - sel=2, 3 frames -> active pixels 000000, 010101, 020202
//  - rst_i pulsed mid-line -> all outputs 0 the next clk; busy_o=0
//  - VTG_BORDER_EN defined -> line 0 and line 3 all FFFFFF; pixels 0 and 15 FFFFFF on every active line

Source files
------------

// File: rtl/vtg_pkg.sv
// Shared types and constants for the video timing generator: pattern select,
// FSM states and the colour-bar palette.
package vtg_pkg;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_RAMP  = 2'd1,
    PAT_LEVEL = 2'd2,
    PAT_BLACK = 2'd3
  } pattern_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [23:0] BORDER_COLOR = 24'hFFFFFF;

  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vtg_pattern.sv
// Combinational pixel generator: maps the current raster position, frame count
// and active pattern to a 24-bit {R,G,B} value, with an optional white border.
module vtg_pattern
  import vtg_pkg::*;
#(
  parameter int CNT_BITS = 12,
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720
) (
  input  logic [CNT_BITS-1:0] hc,
  input  logic [CNT_BITS-1:0] vc,
  input  logic [7:0]          frame_cnt,
  input  pattern_e            pattern,
  input  logic                border_en,
  output logic [23:0]         pixel
);

  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0] bar_idx;
  logic       border;

  always_comb begin
    // Only meaningful inside the active width, where the quotient is 0..7.
    bar_idx = 3'(hc / CNT_BITS'(BAR_W));
    border  = border_en &&
              (hc == '0 || hc == CNT_BITS'(H_ACTIVE - 1) ||
               vc == '0 || vc == CNT_BITS'(V_ACTIVE - 1));
    case (pattern)
      PAT_BARS:  pixel = bar_color(bar_idx);
      PAT_RAMP:  pixel = {3{hc[7:0]}};
      PAT_LEVEL: pixel = {3{frame_cnt}};
      default:   pixel = 24'h000000;
    endcase
    if (border) pixel = BORDER_COLOR;
  end

endmodule

// File: rtl/video_timing_gen.sv
// Video timing generator: h/v raster counters, IDLE/RUN FSM, sync/de decode and
// registered pixel outputs. Define VTG_BORDER_EN to paint a white frame border.
module video_timing_gen
  import vtg_pkg::*;
#(
  parameter int CNT_BITS = 12,
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [1:0]  pattern_sel_i,
  output logic        vs_o,
  output logic        hs_o,
  output logic        de_o,
  output logic [23:0] data_o,
  output logic        frame_start_o,
  output logic        busy_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_BITS-1:0] H_LAST   = CNT_BITS'(H_TOTAL - 1);
  localparam logic [CNT_BITS-1:0] V_LAST   = CNT_BITS'(V_TOTAL - 1);
  localparam logic [CNT_BITS-1:0] H_ACT_C  = CNT_BITS'(H_ACTIVE);
  localparam logic [CNT_BITS-1:0] V_ACT_C  = CNT_BITS'(V_ACTIVE);
  localparam logic [CNT_BITS-1:0] HS_START = CNT_BITS'(H_ACTIVE + H_FP);
  localparam logic [CNT_BITS-1:0] HS_END   = CNT_BITS'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_BITS-1:0] VS_START = CNT_BITS'(V_ACTIVE + V_FP);
  localparam logic [CNT_BITS-1:0] VS_END   = CNT_BITS'(V_ACTIVE + V_FP + V_SYNC);

  state_e              state;
  logic [CNT_BITS-1:0] hc;
  logic [CNT_BITS-1:0] vc;
  logic [7:0]          frame_cnt;
  pattern_e            pat_q;
  pattern_e            pat_now;
  logic                running;
  logic                frame_first;
  logic                de_c;
  logic                hs_c;
  logic                vs_c;
  logic                border_en;
  logic [23:0]         pixel;

`ifdef VTG_BORDER_EN
  assign border_en = 1'b1;
`else
  assign border_en = 1'b0;
`endif

  // The select is sampled on the first pixel of a frame so that pixel already
  // uses the new pattern; it is then held for the rest of the frame.
  always_comb begin
    running     = (state == RUN);
    frame_first = (hc == '0) && (vc == '0);
    pat_now     = frame_first ? pattern_e'(pattern_sel_i) : pat_q;
    de_c        = (hc < H_ACT_C) && (vc < V_ACT_C);
    hs_c        = (hc >= HS_START) && (hc < HS_END);
    vs_c        = (vc >= VS_START) && (vc < VS_END);
  end

  vtg_pattern #(
    .CNT_BITS (CNT_BITS),
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_pattern (
    .hc        (hc),
    .vc        (vc),
    .frame_cnt (frame_cnt),
    .pattern   (pat_now),
    .border_en (border_en),
    .pixel     (pixel)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      hc            <= '0;
      vc            <= '0;
      frame_cnt     <= '0;
      pat_q         <= PAT_BARS;
      vs_o          <= 1'b0;
      hs_o          <= 1'b0;
      de_o          <= 1'b0;
      data_o        <= '0;
      frame_start_o <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      vs_o          <= running && vs_c;
      hs_o          <= running && hs_c;
      de_o          <= running && de_c;
      data_o        <= (running && de_c) ? pixel : '0;
      frame_start_o <= running && frame_first;
      busy_o        <= running;

      case (state)
        IDLE: begin
          hc <= '0;
          vc <= '0;
          if (en_i) state <= RUN;
        end
        RUN: begin
          pat_q <= pat_now;
          if (hc == H_LAST) begin
            hc <= '0;
            if (vc == V_LAST) begin
              // Frame boundary is the only place a stop request takes effect.
              vc        <= '0;
              frame_cnt <= frame_cnt + 8'd1;
              if (!en_i) state <= IDLE;
            end else begin
              vc <= vc + 1'b1;
            end
          end else begin
            hc <= hc + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a small 24x8 raster: a frame-position reference
// model predicts every output cycle by cycle under randomized control.
module tb_video_timing_gen;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 4,  VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic        clk;
  logic        rst;
  logic        en;
  logic [1:0]  sel;
  logic        vs_o, hs_o, de_o, fs_o, busy_o;
  logic [23:0] data_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  // Reference model: running flag, position within the frame, frame count, held select.
  bit m_run = 0;
  int m_pos = 0;
  int m_fcnt = 0;
  int m_sel = 0;

  bit period_chk = 0;
  int last_fs = -1;
  int de_cnt = 0;

  video_timing_gen #(
    .CNT_BITS (12),
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .en_i          (en),
    .pattern_sel_i (sel),
    .vs_o          (vs_o),
    .hs_o          (hs_o),
    .de_o          (de_o),
    .data_o        (data_o),
    .frame_start_o (fs_o),
    .busy_o        (busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // One clock: predict outputs from the pre-edge model state and inputs, then compare.
  task automatic step();
    int x, y, s;
    logic e_de, e_hs, e_vs, e_fs, e_busy;
    logic [23:0] e_data;
    e_de = 0; e_hs = 0; e_vs = 0; e_fs = 0; e_busy = 0; e_data = '0;
    s = m_sel;
    if (!rst && m_run) begin
      x = m_pos % HT;
      y = m_pos / HT;
      s = (m_pos == 0) ? int'(sel) : m_sel;
      e_busy = 1'b1;
      e_fs   = (m_pos == 0);
      e_de   = (x < HA) && (y < VA);
      e_hs   = (x >= HA + HF) && (x < HA + HF + HS);
      e_vs   = (y >= VA + VF) && (y < VA + VF + VS);
      if (e_de) begin
        case (s)
          0:       e_data = bars[x / (HA / 8)];
          1:       e_data = {3{8'(x)}};
          2:       e_data = {3{8'(m_fcnt)}};
          default: e_data = 24'h000000;
        endcase
`ifdef VTG_BORDER_EN
        if (x == 0 || x == HA - 1 || y == 0 || y == VA - 1) e_data = 24'hFFFFFF;
`endif
      end
    end

    @(posedge clk);
    #1;
    cyc++;
    check("de",    32'(de_o),   32'(e_de));
    check("hs",    32'(hs_o),   32'(e_hs));
    check("vs",    32'(vs_o),   32'(e_vs));
    check("fs",    32'(fs_o),   32'(e_fs));
    check("busy",  32'(busy_o), 32'(e_busy));
    check("data",  32'(data_o), 32'(e_data));

    if (!period_chk) begin
      last_fs = -1;
    end else if (fs_o) begin
      if (last_fs >= 0) begin
        check("fs_period",    32'(cyc - last_fs), 32'(FT));
        check("de_per_frame", 32'(de_cnt),        32'(HA * VA));
      end
      last_fs = cyc;
      de_cnt = 0;
    end
    de_cnt += int'(de_o);

    if (rst) begin
      m_run = 0; m_pos = 0; m_fcnt = 0; m_sel = 0;
    end else if (!m_run) begin
      m_run = en; m_pos = 0;
    end else begin
      m_sel = s;
      if (m_pos == FT - 1) begin
        m_pos = 0;
        m_fcnt = (m_fcnt + 1) % 256;
        m_run = en;
      end else begin
        m_pos++;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to_pos(input int p);
    for (int i = 0; i < 2 * FT && !(m_run && m_pos == p); i++) step();
    check("reach_pos", 32'(m_run && m_pos == p), 32'd1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; sel = 2'd0;
    run(3);

    // Free-running frames with the frame-level pattern: 00, 01, 02 ...
    rst = 1'b0; en = 1'b1; sel = 2'd2;
    period_chk = 1;
    run(3 * FT + 5);

    // Bars, then switch to the ramp mid-frame; it must only apply next frame.
    sel = 2'd0;
    run_to_pos(0);
    run(FT + 60);
    sel = 2'd1;
    run(FT + 20);
    period_chk = 0;

    // Stop request mid-frame: frame completes, then idle, then restart.
    sel = 2'd0;
    run_to_pos(50);
    en = 1'b0;
    run(FT);
    check("idle_busy", 32'(busy_o), 32'd0);
    run(20);
    en = 1'b1;
    run(FT / 2);

    // Reset pulse in the middle of a line.
    run_to_pos(30);
    rst = 1'b1;
    run(1);
    check("rst_busy", 32'(busy_o), 32'd0);
    rst = 1'b0;
    run(2 * FT);

    // Randomized control traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 149) == 0) en = ~en;
      if ($urandom_range(0, 39) == 0) sel = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;
    run(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
